// File: rtl/cnn_pkg.sv
// Shared types for the 3x3 convolution front end: pixel and window shapes
// plus the window indices consumers use to pick out specific taps.
package cnn_pkg;

  localparam int PIX_W = 8;

  typedef logic signed [PIX_W-1:0] pixel_t;
  typedef pixel_t window_t [9];

  // Row-major window taps: top-left is oldest row/column, bottom-right is
  // the pixel that completed the window.
  localparam int WIN_TL = 0;
  localparam int WIN_C  = 4;
  localparam int WIN_BR = 8;

endpackage : cnn_pkg

// File: rtl/window_3x3_gen_if.sv
// Pixel-stream in / window-stream out bundle for window_3x3_gen.
// The pixel source holds the master side, the window generator the slave side.
interface window_3x3_gen_if
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W
);

  logic                         valid_i;
  logic                         sof_i;
  logic signed [DATA_WIDTH-1:0] data_i;
  logic signed [DATA_WIDTH-1:0] window_o [9];
  logic                         valid_o;
  logic                         last_o;

  modport master (
    output valid_i, sof_i, data_i,
    input  window_o, valid_o, last_o
  );

  modport slave (
    input  valid_i, sof_i, data_i,
    output window_o, valid_o, last_o
  );

endinterface : window_3x3_gen_if

// File: rtl/line_buffer.sv
// One image row of delay: single-address memory indexed by column.
// dout shows the pre-write contents of addr, and the consumer captures it on
// the same edge that performs the write, so read and write stay aligned.
module line_buffer #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Store the incoming column value; no reset, contents are masked downstream.
  always_ff @(posedge clk) begin
    if (en) begin
      mem_r[addr] <= din;
    end
  end

  assign dout = mem_r[addr];

endmodule : line_buffer

// File: rtl/window_3x3_gen.sv
// Raster-stream to 3x3 neighbourhood generator. Two line buffers hold the
// previous rows; a 3x3 shift array presents each complete "valid" window
// (no padding) one cycle after the pixel that completes it.
module window_3x3_gen
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = PIX_W,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 96,
  parameter int COL_W      = $clog2(IMG_WIDTH),
  parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic             clk,
  input  logic             reset_n,
  window_3x3_gen_if.slave  bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]            col_r;
  logic [ROW_W-1:0]            row_r;
  logic                        frame_active_r;
  logic                        valid_r;
  logic                        last_r;
  logic signed [DATA_WIDTH-1:0] win_r [9];

  logic                        accept_s;
  logic [COL_W-1:0]            cur_col_s;
  logic [ROW_W-1:0]            cur_row_s;
  logic                        col_last_s;
  logic                        row_last_s;
  logic                        win_ready_s;
  logic [DATA_WIDTH-1:0]       lb0_dout_s;
  logic [DATA_WIDTH-1:0]       lb1_dout_s;

  // Position of the pixel on the bus; sof forces (0,0) and resynchronises.
  always_comb begin
    accept_s = bus.valid_i & (bus.sof_i | frame_active_r);
    if (bus.sof_i) begin
      cur_col_s = {COL_W{1'b0}};
      cur_row_s = {ROW_W{1'b0}};
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    col_last_s  = (cur_col_s == COL_LAST);
    row_last_s  = (cur_row_s == ROW_LAST);
    win_ready_s = (cur_row_s >= ROW_W'(2)) && (cur_col_s >= COL_W'(2));
  end

  // Row/column tracking; the frame closes after its final pixel.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      col_r          <= {COL_W{1'b0}};
      row_r          <= {ROW_W{1'b0}};
      frame_active_r <= 1'b0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= {COL_W{1'b0}};
        if (row_last_s) begin
          row_r          <= {ROW_W{1'b0}};
          frame_active_r <= 1'b0;
        end else begin
          row_r          <= cur_row_s + ROW_W'(1);
          frame_active_r <= 1'b1;
        end
      end else begin
        col_r          <= cur_col_s + COL_W'(1);
        row_r          <= cur_row_s;
        frame_active_r <= 1'b1;
      end
    end
  end

  // lb1 delays by one row, lb0 by two: lb0 takes lb1's outgoing value.
  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_lb1 (
    .clk  (clk),
    .en   (accept_s),
    .addr (cur_col_s),
    .din  (bus.data_i),
    .dout (lb1_dout_s)
  );

  line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(DATA_WIDTH), .AW(COL_W)) u_lb0 (
    .clk  (clk),
    .en   (accept_s),
    .addr (cur_col_s),
    .din  (lb1_dout_s),
    .dout (lb0_dout_s)
  );

  // Window array: shift columns left and load the new column on each accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 9; k++) begin
        win_r[k] <= {DATA_WIDTH{1'b0}};
      end
    end else if (accept_s) begin
      for (int r = 0; r < 3; r++) begin
        win_r[3*r]     <= win_r[3*r + 1];
        win_r[3*r + 1] <= win_r[3*r + 2];
      end
      win_r[2]      <= $signed(lb0_dout_s);
      win_r[5]      <= $signed(lb1_dout_s);
      win_r[WIN_BR] <= bus.data_i;
    end
  end

  // Strobes: a window exists only once two rows and two columns are behind us.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end else begin
      valid_r <= accept_s & win_ready_s;
      last_r  <= accept_s & win_ready_s & col_last_s & row_last_s;
    end
  end

  assign bus.window_o = win_r;
  assign bus.valid_o  = valid_r;
  assign bus.last_o   = last_r;

endmodule : window_3x3_gen

// File: tb/tb_window_3x3_gen.sv
// Directed bench for window_3x3_gen on a 5x4 image. Pixel (r,c) carries
// base + (r<<4 | c); each expected window is built from that rule.
module tb_window_3x3_gen;
  import cnn_pkg::*;

  localparam int W = 5;
  localparam int H = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 1'b0;
  bit   cst_mode = 1'b0;

  typedef struct {
    int          due;
    logic [71:0] win;
    logic        last;
  } exp_t;

  exp_t exp_q [$];

  window_3x3_gen_if #(.DATA_WIDTH(8)) bus ();

  window_3x3_gen #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [71:0] pack_win();
    logic [71:0] p;
    for (int k = 0; k < 9; k++) p[8*k +: 8] = bus.window_o[k];
    return p;
  endfunction

  function automatic logic [7:0] pix(input logic [7:0] base, input bit cst, input int r, input int c);
    logic [7:0] v;
    if (cst) v = 8'h80;
    else     v = base + 8'((r << 4) | c);
    return v;
  endfunction

  function automatic logic [71:0] exp_win(input logic [7:0] base, input bit cst, input int r, input int c);
    logic [71:0] p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[8*(3*i + j) +: 8] = pix(base, cst, r - 2 + i, c - 2 + j);
    return p;
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(posedge clk); #1;
    bus.valid_i = v;
    bus.sof_i   = s;
    bus.data_i  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  // Send pixels idx in [first, stop) of a frame in raster order.
  task automatic send_frame(input logic [7:0] base, input bit cst, input int first, input int stop,
                            input bit gaps, input bit sof_en, input bit exp_en);
    for (int idx = first; idx < stop; idx++) begin
      int r;
      int c;
      r = idx / W;
      c = idx % W;
      drive(1'b1, sof_en && (idx == first), pix(base, cst, r, c));
      if (exp_en && r >= 2 && c >= 2)
        exp_q.push_back('{cyc + 1, exp_win(base, cst, r, c), (r == H - 1) && (c == W - 1)});
      if (gaps) begin
        if (c == W - 1) begin
          idle(7);
          if (exp_en && r >= 2) check_val("gap_hold", pack_win(), exp_win(base, cst, r, c));
        end else begin
          idle(1);
        end
      end
    end
  endtask

  task automatic drain(input string tag);
    idle(3);
    check_val(tag, 72'(exp_q.size()), 72'd0);
    exp_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_valid"}, 72'(bus.valid_o), 72'd0);
    check_val({tag, "_last"}, 72'(bus.last_o), 72'd0);
    check_val({tag, "_window"}, pack_win(), 72'd0);
  endtask

  // Every cycle: either the scheduled window appears, or nothing does.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        int   s;
        e = exp_q.pop_front();
        check_val("valid_o", 72'(bus.valid_o), 72'd1);
        check_val("window", pack_win(), e.win);
        check_val("last_o", 72'(bus.last_o), 72'(e.last));
        if (cst_mode) begin
          s = 0;
          for (int k = 0; k < 9; k++) s += int'(bus.window_o[k]);
          check_val("conv_sum", 72'(s), 72'(-1152));
          check_val("centre_signed", 72'(int'(bus.window_o[WIN_C])), 72'(-128));
        end
      end else begin
        check_val("no_window", 72'({bus.valid_o, bus.last_o}), 72'd0);
      end
    end
  end

  initial begin
    bus.valid_i = 1'b0;
    bus.sof_i   = 1'b0;
    bus.data_i  = 8'sh00;
    reset_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Continuous frame
    send_frame(8'h00, 1'b0, 0, W*H, 1'b0, 1'b1, 1'b1);
    drain("cont_drain");

    // Gapped frame: every other cycle idle, 7 idle cycles at each row end
    send_frame(8'h00, 1'b0, 0, W*H, 1'b1, 1'b1, 1'b1);
    drain("gap_drain");

    // Back-to-back frames, second offset by 0x40
    send_frame(8'h00, 1'b0, 0, W*H, 1'b0, 1'b1, 1'b1);
    send_frame(8'h40, 1'b0, 0, W*H, 1'b0, 1'b1, 1'b1);
    drain("b2b_drain");

    // Frame abandoned at (2,3) by a fresh sof, then a full frame
    send_frame(8'h00, 1'b0, 0, 2*W + 3, 1'b0, 1'b1, 1'b1);
    send_frame(8'h00, 1'b0, 0, W*H, 1'b0, 1'b1, 1'b1);
    drain("resync_drain");

    // Reset during row 2, then a stream without sof, then a proper frame
    send_frame(8'h00, 1'b0, 0, 2*W + 3, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    reset_n     = 1'b0;
    bus.valid_i = 1'b1;
    bus.sof_i   = 1'b0;
    bus.data_i  = 8'sh23;
    @(posedge clk); #1;
    reset_n     = 1'b1;
    bus.valid_i = 1'b0;
    check_cleared("midrst");
    send_frame(8'h00, 1'b0, 2*W + 3, W*H, 1'b0, 1'b0, 1'b0);
    send_frame(8'h00, 1'b0, 0, W*H, 1'b0, 1'b0, 1'b0);
    drain("nosof_drain");
    send_frame(8'h00, 1'b0, 0, W*H, 1'b0, 1'b1, 1'b1);
    drain("postrst_drain");

    // Signed extreme: every pixel -128
    cst_mode = 1'b1;
    send_frame(8'h00, 1'b1, 0, W*H, 1'b0, 1'b1, 1'b1);
    drain("signed_drain");
    cst_mode = 1'b0;

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_window_3x3_gen

// File: doc/window_3x3_gen.md
Name: window_3x3_gen

Overview:
- Upstream stage of the 3x3 convolution. Accepts a raster-order pixel stream, one pixel per cycle with optional gaps.
- Keeps the two previous image rows in line buffers.
- Presents each complete 3x3 neighbourhood as nine parallel signed words with a valid strobe, ready to drive the convolution's data_i[9] directly.
- Output is "valid" convolution only: no padding, (IMG_WIDTH-2)x(IMG_HEIGHT-2) windows per frame.

Parameters:
- DATA_WIDTH, 8, pixel width (signed, passed through unmodified).
- IMG_WIDTH, 128, pixels per row; legal range 3 and up.
- IMG_HEIGHT, 96, rows per frame; legal range 3 and up.
- COL_W, $clog2(IMG_WIDTH), column counter width (derived).
- ROW_W, $clog2(IMG_HEIGHT), row counter width (derived).

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  synchronous active-low reset.
- valid_i  in  1  input pixel strobe.
- sof_i  in  1  start of frame; qualified by valid_i; marks the pixel at (0,0).
- data_i  in  DATA_WIDTH signed  input pixel.
- window_o  out  DATA_WIDTH signed x9 (unpacked [9])  row-major window; [0] top-left (oldest row, oldest column), [4] centre, [8] bottom-right (current pixel).
- valid_o  out  1  window_o holds a complete window.
- last_o  out  1  with valid_o, marks the final window of the frame.

Behaviour:
- Reset (reset_n=0 at a clk edge): col and row counters go to 0. valid_o=0, last_o=0, all window_o entries=0, frame_active=0. Line buffer contents are not reset; they are don't-care because output gating masks them.
- Accept: a pixel is consumed only on cycles with valid_i=1. With valid_i=0, all state holds, including window_o. valid_o drops to 0.
- Pixel position:
  - valid_i & sof_i forces the current pixel to (row 0, col 0) and sets frame_active=1, regardless of counter state. This resynchronises mid-frame; the partial frame is abandoned and no last_o is issued for it.
  - Otherwise col increments. At col=IMG_WIDTH-1 col wraps to 0 and row increments. At row=IMG_HEIGHT-1, col=IMG_WIDTH-1 both wrap to 0 and frame_active clears.
- Pixels with frame_active=0 and sof_i=0 are ignored: no buffer write, no output.
- Line buffers: two IMG_WIDTH-deep delay lines addressed by col. For each accepted pixel:
  - lb1 reads the pixel from one row above; lb0 reads the pixel from two rows above.
  - lb0 is then written with lb1's old value, and lb1 with data_i (read-before-write, same address).
- Window shift register: a 3x3 register array. On each accepted pixel, columns shift left: old column 1 moves to column 0, old column 2 to column 1. The new column 2 is {lb0 out, lb1 out, data_i} for rows {0,1,2}.
- valid_o: registered, asserted the cycle after accepting the pixel at (r,c) with r>=2 and c>=2. That window is centred on (r-1,c-1). Latency from that pixel to valid_o is 1 cycle.
- Row wrap: no window is emitted for c<2, so stale columns from the previous row are never exposed.
- last_o: asserted with valid_o for the window of pixel (IMG_HEIGHT-1, IMG_WIDTH-1); 0 otherwise.
- Back-to-back frames: a sof_i pixel immediately after the last pixel of the previous frame needs no idle cycles.
- Reset mid-frame: all output cleared next cycle. The stream is ignored until the next sof_i.
- Arithmetic: none on data. Counter compares are against IMG_WIDTH-1 and IMG_HEIGHT-1 only.

Decomposition:
- Shared package cnn_pkg:
  - pixel_t, typedef logic signed [DATA_WIDTH-1:0].
  - window_t, typedef pixel_t [9].
  - Localparam indices WIN_TL=0, WIN_C=4, WIN_BR=8 for consumers.
- One sub-module, line_buffer:
  - Parameters DEPTH and WIDTH.
  - Ports clk, en, addr, din, dout.
  - Single address, read-before-write; registered read aligned to the write cycle.
  - Instantiated twice.
- Counters, gating and the window array stay in the top module.

Test Plan:
- Overrides W=5, H=4. Continuous frame, pixel=(r<<4)|c, sof_i on the first pixel -> first valid_o 1 cycle after pixel 0x22, with window_o={00,01,02,10,11,12,20,21,22}. Exactly 6 valid windows. The last window is {12,13,14,22,23,24,32,33,34} with last_o=1.
- Same frame with valid_i deasserted every other cycle, plus a 7-cycle gap at each row end -> identical window sequence. valid_o is never high during gaps. window_o holds during gaps.
- Two frames back-to-back, frame 2 data = frame 1 + 0x40 -> the first window of frame 2 is {40,41,42,50,51,52,60,61,62}. No window mixes frame-1 and frame-2 rows.
- sof_i reasserted at pixel (2,3) of frame 1, then a full frame -> no last_o for frame 1. The following frame yields exactly 6 correct windows.
- reset_n=0 for 1 cycle during row 2 -> next cycle valid_o=0, last_o=0, window_o all 0. Pixels without a preceding sof_i produce no output. The next sof_i frame is correct.
- Signed values: a frame of all 8'h80 (-128) -> every window entry = -128. Drive into the convolution with kernel all 1 -> data_o = -1152 after its pipeline latency.
